// File: rtl/lcd_bus_monitor.sv
// Emulated HD44780-style LCD controller: samples the driver's rs/e/data pins,
// pairs nibbles into bytes, decodes the command set and keeps a 2x16 character buffer.
`timescale 1ns/1ps
module lcd_bus_monitor #(
    parameter int         SYNC_STAGES  = 2,
    parameter logic [7:0] CLEAR_FILL   = 8'h20,
    parameter int         CLEAR_CYCLES = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_rs,
    input  logic       lcd_e,
    input  logic [3:0] lcd_data,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic       byte_valid,
    output logic [7:0] byte_out,
    output logic       byte_is_data,
    output logic [4:0] cursor_pos,
    output logic       display_on,
    output logic       mode4,
    output logic       busy,
    output logic       err_overrun
);

    localparam int              CNT_W    = $clog2(CLEAR_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_CELLS = CNT_W'(32);

    typedef enum logic [1:0] {
        S_INIT8 = 2'd0,
        S_HI    = 2'd1,
        S_LO    = 2'd2
    } nib_state_t;

    logic [5:0]       sync_r [SYNC_STAGES];
    logic             e_prev_r;
    logic             rs_s;
    logic             e_s;
    logic [3:0]       nib_s;
    logic             strobe_s;

    nib_state_t       state_r;
    logic [3:0]       hi_r;
    logic             byte_valid_r;
    logic [7:0]       byte_out_r;
    logic             byte_is_data_r;
    logic             mode4_r;

    logic [4:0]       cursor_r;
    logic             inc_r;
    logic             cgram_sel_r;
    logic             display_on_r;
    logic             busy_r;
    logic [CNT_W-1:0] clr_cnt_r;
    logic             err_overrun_r;

    logic [7:0]       mem_r [32];
    logic [7:0]       rd_char_r;

    logic             wr_en_s;
    logic [4:0]       wr_addr_s;
    logic [7:0]       wr_data_s;
    logic [4:0]       cur_inc_s;
    logic [4:0]       cur_dec_s;

    // Input synchronizer chain plus the enable edge-detect register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= 6'h00;
            end
            e_prev_r <= 1'b0;
        end else begin
            sync_r[0] <= {lcd_rs, lcd_e, lcd_data};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            e_prev_r <= sync_r[SYNC_STAGES-1][4];
        end
    end

    assign rs_s     = sync_r[SYNC_STAGES-1][5];
    assign e_s      = sync_r[SYNC_STAGES-1][4];
    assign nib_s    = sync_r[SYNC_STAGES-1][3:0];
    assign strobe_s = e_prev_r & ~e_s;

    // Nibble pairing FSM; strobes arriving during Clear are dropped here
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r        <= S_INIT8;
            hi_r           <= 4'h0;
            byte_valid_r   <= 1'b0;
            byte_out_r     <= 8'h00;
            byte_is_data_r <= 1'b0;
            mode4_r        <= 1'b0;
        end else begin
            byte_valid_r <= 1'b0;
            if (strobe_s && !busy_r) begin
                case (state_r)
                    S_INIT8: begin
                        byte_valid_r   <= 1'b1;
                        byte_out_r     <= {nib_s, 4'h0};
                        byte_is_data_r <= rs_s;
                        // Function Set with DL=0 switches to nibble pairing
                        if (!rs_s && nib_s == 4'h2) begin
                            state_r <= S_HI;
                            mode4_r <= 1'b1;
                        end
                    end
                    S_HI: begin
                        hi_r    <= nib_s;
                        state_r <= S_LO;
                    end
                    S_LO: begin
                        byte_valid_r   <= 1'b1;
                        byte_out_r     <= {hi_r, nib_s};
                        byte_is_data_r <= rs_s;
                        if (!rs_s && hi_r == 4'h3) begin
                            state_r <= S_INIT8;
                            mode4_r <= 1'b0;
                        end else begin
                            state_r <= S_HI;
                        end
                    end
                    default: begin
                        state_r <= S_INIT8;
                        mode4_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign cur_inc_s = cursor_r + 5'd1;
    assign cur_dec_s = cursor_r - 5'd1;

    // Command decode, cursor movement and the Clear sequencer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cursor_r      <= 5'd0;
            inc_r         <= 1'b1;
            cgram_sel_r   <= 1'b0;
            display_on_r  <= 1'b0;
            busy_r        <= 1'b0;
            clr_cnt_r     <= '0;
            err_overrun_r <= 1'b0;
        end else begin
            if (strobe_s && busy_r) begin
                err_overrun_r <= 1'b1;
            end
            if (busy_r) begin
                clr_cnt_r <= clr_cnt_r + CNT_W'(1);
                if (clr_cnt_r == CNT_LAST) begin
                    busy_r   <= 1'b0;
                    cursor_r <= 5'd0;
                    inc_r    <= 1'b1;
                end
            end else if (byte_valid_r) begin
                if (byte_is_data_r) begin
                    if (!cgram_sel_r) begin
                        cursor_r <= inc_r ? cur_inc_s : cur_dec_s;
                    end
                end else begin
                    casez (byte_out_r)
                        8'b1???????: begin
                            cursor_r    <= {byte_out_r[6], byte_out_r[3:0]};
                            cgram_sel_r <= 1'b0;
                        end
                        8'b01??????: cgram_sel_r <= 1'b1;
                        8'b001?????: cgram_sel_r <= cgram_sel_r;
                        8'b0001????: begin
                            if (!byte_out_r[3]) begin
                                cursor_r <= byte_out_r[2] ? cur_inc_s : cur_dec_s;
                            end
                        end
                        8'b00001???: display_on_r <= byte_out_r[2];
                        8'b000001??: inc_r <= byte_out_r[1];
                        8'b0000001?: cursor_r <= 5'd0;
                        8'b00000001: begin
                            busy_r    <= 1'b1;
                            clr_cnt_r <= '0;
                        end
                        default: cgram_sel_r <= cgram_sel_r;
                    endcase
                end
            end
        end
    end

    // Single buffer write port shared by Clear and data writes
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = 5'd0;
        wr_data_s = 8'h00;
        if (busy_r) begin
            if (clr_cnt_r < CNT_CELLS) begin
                wr_en_s   = 1'b1;
                wr_addr_s = clr_cnt_r[4:0];
                wr_data_s = CLEAR_FILL;
            end else begin
                wr_en_s   = 1'b0;
            end
        end else if (byte_valid_r && byte_is_data_r && !cgram_sel_r) begin
            wr_en_s   = 1'b1;
            wr_addr_s = cursor_r;
            wr_data_s = byte_out_r;
        end else begin
            wr_en_s   = 1'b0;
        end
    end

    // Display buffer storage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                mem_r[i] <= CLEAR_FILL;
            end
        end else if (wr_en_s) begin
            mem_r[wr_addr_s] <= wr_data_s;
        end
    end

    // Registered read port; a same-cycle write is seen one cycle later
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_char_r <= 8'h00;
        end else begin
            rd_char_r <= mem_r[rd_addr];
        end
    end

    assign rd_char      = rd_char_r;
    assign byte_valid   = byte_valid_r;
    assign byte_out     = byte_out_r;
    assign byte_is_data = byte_is_data_r;
    assign cursor_pos   = cursor_r;
    assign display_on   = display_on_r;
    assign mode4        = mode4_r;
    assign busy         = busy_r;
    assign err_overrun  = err_overrun_r;

endmodule
